// File: rtl/controlador_divisao.sv
// Restoring divider controller: W_DIV-bit dividend by a 4-bit divisor, one quotient bit per cycle.
// The subtractor lives outside this block on the sub_* ports; this block only sequences it.
module controlador_divisao #(
  parameter int W_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [W_DIV-1:0] dividendo,
  input  logic [3:0]       divisor,
  output logic             ocupado,
  output logic             pronto,
  output logic [W_DIV-1:0] quociente,
  output logic [3:0]       resto,
  output logic             erro_div0,
  output logic [4:0]       sub_a,
  output logic [3:0]       sub_b,
  output logic             sub_modo,
  output logic             sub_cin,
  input  logic [4:0]       sub_s,
  input  logic             sub_cout,
  output logic [1:0]       estado
);

  localparam int CW = (W_DIV > 2) ? $clog2(W_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(W_DIV - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  estado_t          state;
  logic [3:0]       rem_reg;
  logic [W_DIV-1:0] q_reg;
  logic [3:0]       div_reg;
  logic [CW-1:0]    contador;
  logic             err_reg;
  logic             sub_s_unused;

  // Operands come straight from registers so the adder path starts at a flop.
  assign sub_a        = {rem_reg, q_reg[W_DIV-1]};
  assign sub_b        = div_reg;
  assign sub_modo     = 1'b1;
  assign sub_cin      = 1'b1;
  assign sub_s_unused = sub_s[4];
  assign estado       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCIOSO;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      quociente <= '0;
      resto     <= '0;
      erro_div0 <= 1'b0;
      rem_reg   <= '0;
      q_reg     <= '0;
      div_reg   <= '0;
      contador  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state)
        OCIOSO: begin
          pronto <= 1'b0;
          if (inicio) begin
            ocupado <= 1'b1;
            if (divisor != 4'd0) begin
              q_reg    <= dividendo;
              rem_reg  <= '0;
              div_reg  <= divisor;
              contador <= '0;
              err_reg  <= 1'b0;
              state    <= CALCULA;
            end else begin
              // Divide by zero skips the iterations and reports all-ones.
              err_reg <= 1'b1;
              q_reg   <= '1;
              rem_reg <= '0;
              state   <= CONCLUI;
            end
          end else begin
            ocupado <= 1'b0;
          end
        end
        CALCULA: begin
          ocupado  <= 1'b1;
          pronto   <= 1'b0;
          rem_reg  <= sub_cout ? sub_s[3:0] : sub_a[3:0];
          q_reg    <= {q_reg[W_DIV-2:0], sub_cout};
          contador <= contador + 1'b1;
          if (contador == LAST) state <= CONCLUI;
        end
        CONCLUI: begin
          quociente <= q_reg;
          resto     <= rem_reg;
          erro_div0 <= err_reg;
          pronto    <= 1'b1;
          ocupado   <= 1'b0;
          state     <= OCIOSO;
        end
        default: begin
          ocupado <= 1'b0;
          pronto  <= 1'b0;
          state   <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_divisao.sv
// Bench for controlador_divisao: behavioural adder on the sub_* ports, arithmetic reference model,
// per-cycle compare process plus directed literal checks and a random sweep.
module tb_controlador_divisao;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         inicio = 1'b0;
  logic [W-1:0] dividendo = '0;
  logic [3:0]   divisor = '0;
  logic         ocupado, pronto, erro_div0;
  logic [W-1:0] quociente;
  logic [3:0]   resto;
  logic [4:0]   sub_a;
  logic [3:0]   sub_b;
  logic         sub_modo, sub_cin;
  logic [4:0]   sub_s;
  logic         sub_cout;
  logic [1:0]   estado;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  controlador_divisao #(.W_DIV(W)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .dividendo(dividendo), .divisor(divisor),
    .ocupado(ocupado), .pronto(pronto), .quociente(quociente), .resto(resto),
    .erro_div0(erro_div0), .sub_a(sub_a), .sub_b(sub_b), .sub_modo(sub_modo),
    .sub_cin(sub_cin), .sub_s(sub_s), .sub_cout(sub_cout), .estado(estado)
  );

  // Shared add/sub unit in subtract mode: a + ~b + 1.
  assign sub_s    = sub_a - {1'b0, sub_b};
  assign sub_cout = (sub_a >= {1'b0, sub_b});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is a fixed-length busy window ending in a result pulse.
  int           m_remaining;
  logic         m_ocup, m_pronto, m_err;
  logic [W-1:0] m_q;
  logic [3:0]   m_r;
  logic [W-1:0] p_q;
  logic [3:0]   p_r;
  logic         p_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remaining = 0;
      m_ocup = 0; m_pronto = 0; m_err = 0; m_q = '0; m_r = '0;
    end else begin
      m_pronto = 0;
      if (m_remaining == 0) begin
        if (inicio) begin
          if (divisor == 0) begin
            p_q = '1; p_r = '0; p_e = 1'b1; m_remaining = 1;
          end else begin
            p_q = W'(dividendo / divisor); p_r = 4'(dividendo % divisor); p_e = 1'b0;
            m_remaining = W + 1;
          end
        end
      end else begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_pronto = 1; m_q = p_q; m_r = p_r; m_err = p_e;
        end
      end
      m_ocup = (m_remaining != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ocupado", ocupado, m_ocup);
      chk("cyc_pronto", pronto, m_pronto);
      chk("cyc_quociente", quociente, m_q);
      chk("cyc_resto", resto, m_r);
      chk("cyc_erro_div0", erro_div0, m_err);
      chk("cyc_sub_modo", sub_modo, 1'b1);
      chk("cyc_sub_cin", sub_cin, 1'b1);
    end
  end

  task automatic start(input logic [W-1:0] dvd, input logic [3:0] dvs);
    inicio = 1'b1; dividendo = dvd; divisor = dvs;
    @(posedge clk); #1;
    inicio = 1'b0;
  endtask

  // Counts edges from the acceptance edge until pronto is seen.
  task automatic wait_pronto(input string name, output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (pronto) break;
      if (n >= 40) begin
        chk({name, "_timeout"}, 1, 0);
        break;
      end
    end
  endtask

  task automatic run_div(input string name, input logic [W-1:0] dvd, input logic [3:0] dvs,
                         input int lat, input logic [W-1:0] eq, input logic [3:0] er,
                         input logic ee);
    int n;
    start(dvd, dvs);
    chk({name, "_ocupado_start"}, ocupado, 1'b1);
    wait_pronto(name, n);
    chk({name, "_latency"}, n, lat);
    chk({name, "_q"}, quociente, eq);
    chk({name, "_r"}, resto, er);
    chk({name, "_err"}, erro_div0, ee);
    @(posedge clk); #1;
    chk({name, "_pronto_width"}, pronto, 1'b0);
  endtask

  initial begin
    int n;
    int dvd, dvs, gap;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_ocupado", ocupado, 0);
    chk("reset_pronto", pronto, 0);
    chk("reset_q", quociente, 0);
    chk("reset_r", resto, 0);
    chk("reset_err", erro_div0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div("basic_200_7", 200, 7, 9, 28, 4, 0);
    run_div("edge_255_1", 255, 1, 9, 255, 0, 0);
    run_div("edge_5_9", 5, 9, 9, 0, 5, 0);
    run_div("edge_255_15", 255, 15, 9, 17, 0, 0);
    run_div("div0_100_0", 100, 0, 1, 8'hFF, 0, 1);
    run_div("after_div0_100_10", 100, 10, 9, 10, 0, 0);

    // Request while busy must be dropped.
    start(200, 7);
    repeat (3) @(posedge clk);
    #1;
    start(50, 3);
    wait_pronto("ignored", n);
    chk("ignored_q", quociente, 28);
    chk("ignored_r", resto, 4);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("ignored_no_second_pronto", pronto, 0);
    end

    // Back-to-back: new request in the pronto cycle.
    start(30, 4);
    wait_pronto("b2b_first", n);
    chk("b2b_first_q", quociente, 7);
    chk("b2b_first_r", resto, 2);
    start(77, 5);
    wait_pronto("b2b_second", n);
    chk("b2b_second_latency", n, 9);
    chk("b2b_second_q", quociente, 15);
    chk("b2b_second_r", resto, 2);
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    start(200, 7);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_pronto", pronto, 0);
    chk("midrst_q", quociente, 0);
    chk("midrst_r", resto, 0);
    chk("midrst_err", erro_div0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_pronto", pronto, 0);
    end
    run_div("after_rst_13_2", 13, 2, 9, 6, 1, 0);

    // Random sweep against plain integer division.
    for (int t = 0; t < 1000; t++) begin
      dvd = $urandom_range(0, 255);
      dvs = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 15);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
      if (dvs == 0)
        run_div("rand", W'(dvd), 4'(dvs), 1, 8'hFF, 0, 1);
      else
        run_div("rand", W'(dvd), 4'(dvs), 9, W'(dvd / dvs), 4'(dvd % dvs), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
